// File: rtl/clk_div_ctrl_pkg.sv
// Shared definitions for the clk_div sequencer: FSM state encoding,
// requester indices and parameter defaults.
package clk_div_ctrl_pkg;

   localparam int RATIO_W_DEF   = 3;
   localparam int RST_RATIO_DEF = 2;

   // requester 0 is software config, requester 1 is the power manager
   localparam int REQ_SW = 0;
   localparam int REQ_PM = 1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GATE     = 3'd1,
      ST_WAIT_LOW = 3'd2,
      ST_LOAD     = 3'd3,
      ST_SETTLE   = 3'd4,
      ST_ENABLE   = 3'd5
   } state_t;

endpackage

// File: rtl/clk_div_ctrl_rr_arb.sv
// Two-way round-robin arbiter. Grants only while the sequencer is idle;
// after every grant the pointer moves to the requester that lost.
module clk_div_ctrl_rr_arb
   import clk_div_ctrl_pkg::*;
(
   input  logic       i_ref_clk,
   input  logic       i_rst,
   input  logic       i_idle,
   input  logic [1:0] i_req_valid,
   output logic [1:0] o_grant,
   output logic       o_gnt_idx
);

   logic       r_ptr;
   logic [1:0] w_grant;

   // one-hot grant: a lone valid wins, a tie goes to the pointer's side
   always_comb begin
      w_grant = 2'b00;
      if (i_idle) begin
         if (i_req_valid[REQ_SW] && (!i_req_valid[REQ_PM] || !r_ptr))
            w_grant[REQ_SW] = 1'b1;
         else if (i_req_valid[REQ_PM])
            w_grant[REQ_PM] = 1'b1;
      end
   end

   assign o_grant   = w_grant;
   assign o_gnt_idx = w_grant[REQ_PM];

   // pointer update: point at the requester that was not just served
   always_ff @(posedge i_ref_clk) begin
      if (i_rst)
         r_ptr <= 1'b0;
      else if (|w_grant)
         r_ptr <= ~w_grant[REQ_PM];
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free ratio change sequencer in front of clk_div.
// Optional build macro CLK_DIV_CTRL_CNT_EN adds o_chg_cnt, a wrapping
// count of ratio loads (same-ratio requests are not counted).
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   IDLE     | follow i_clk_en, accept a request
//   GATE     | drop divider enable, raise busy, arm wait timer
//   WAIT_LOW | wait for i_div_clk low on two consecutive edges or timer
//   LOAD     | drive the new ratio to the divider
//   SETTLE   | hold the divider disabled for SETTLE_CYC cycles
//   ENABLE   | restore enable from i_clk_en, pulse done
module clk_div_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int RATIO_W    = RATIO_W_DEF,
   parameter int RST_RATIO  = RST_RATIO_DEF,
   parameter int SETTLE_CYC = 2,
   parameter int WAIT_MAX   = 16
) (
   input  logic               i_ref_clk,
   input  logic               i_rst,
   input  logic               i_clk_en,
   input  logic [1:0]         i_req_valid,
   input  logic [RATIO_W-1:0] i_req_ratio0,
   input  logic [RATIO_W-1:0] i_req_ratio1,
   output logic [1:0]         o_req_ready,
   input  logic               i_div_clk,
   output logic [RATIO_W-1:0] o_div_ratio,
   output logic               o_clk_en,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_timeout
`ifdef CLK_DIV_CTRL_CNT_EN
   ,
   output logic [7:0]         o_chg_cnt
`endif
);

   // one timer serves both the low-wait limit and the settle interval
   localparam int TMR_MAX = (WAIT_MAX > SETTLE_CYC) ? WAIT_MAX : SETTLE_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   state_t             r_state;
   logic [RATIO_W-1:0] r_new_ratio;
   logic [RATIO_W-1:0] r_div_ratio;
   logic               r_clk_en;
   logic               r_busy;
   logic               r_done;
   logic               r_timeout;
   logic               r_low_seen;
   logic [TMR_W-1:0]   r_tmr;

   logic               w_idle;
   logic [1:0]         w_grant;
   logic               w_gnt_idx;
   logic               w_accept;
   logic [RATIO_W-1:0] w_acc_ratio;

   assign w_idle      = (r_state == ST_IDLE);
   assign w_accept    = |w_grant;
   assign w_acc_ratio = w_gnt_idx ? i_req_ratio1 : i_req_ratio0;

   clk_div_ctrl_rr_arb u_arb (
      .i_ref_clk   (i_ref_clk),
      .i_rst       (i_rst),
      .i_idle      (w_idle),
      .i_req_valid (i_req_valid),
      .o_grant     (w_grant),
      .o_gnt_idx   (w_gnt_idx)
   );

   // change sequencer; all divider-facing outputs are registered here
   always_ff @(posedge i_ref_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_new_ratio <= RATIO_W'(RST_RATIO);
         r_div_ratio <= RATIO_W'(RST_RATIO);
         r_clk_en    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_low_seen  <= 1'b0;
         r_tmr       <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_clk_en <= i_clk_en;
               if (w_accept) begin
                  r_new_ratio <= w_acc_ratio;
                  // an unchanged ratio needs no gating at all
                  if (w_acc_ratio == r_div_ratio)
                     r_done <= 1'b1;
                  else
                     r_state <= ST_GATE;
               end
            end
            ST_GATE: begin
               r_clk_en   <= 1'b0;
               r_busy     <= 1'b1;
               r_low_seen <= 1'b0;
               r_tmr      <= TMR_W'(WAIT_MAX - 1);
               r_state    <= ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
               // a genuine low pair wins over a timer that expires on the same edge
               if (!i_div_clk && r_low_seen) begin
                  r_state <= ST_LOAD;
               end else if (r_tmr == '0) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_LOAD;
               end else begin
                  r_tmr      <= r_tmr - 1'b1;
                  r_low_seen <= !i_div_clk;
               end
            end
            ST_LOAD: begin
               r_div_ratio <= r_new_ratio;
               r_tmr       <= TMR_W'(SETTLE_CYC - 1);
               r_state     <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (r_tmr == '0)
                  r_state <= ST_ENABLE;
               else
                  r_tmr <= r_tmr - 1'b1;
            end
            ST_ENABLE: begin
               r_clk_en <= i_clk_en;
               r_busy   <= 1'b0;
               r_done   <= 1'b1;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef CLK_DIV_CTRL_CNT_EN
   logic [7:0] r_chg_cnt;

   // count ratio loads, wrapping at 255
   always_ff @(posedge i_ref_clk) begin
      if (i_rst)
         r_chg_cnt <= 8'd0;
      else if (r_state == ST_LOAD)
         r_chg_cnt <= r_chg_cnt + 8'd1;
   end

   assign o_chg_cnt = r_chg_cnt;
`endif

   assign o_req_ready = w_grant;
   assign o_div_ratio = r_div_ratio;
   assign o_clk_en    = r_clk_en;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl with a transaction-level reference model.
module tb_clk_div_ctrl;

   localparam int         WAIT_MAX = 16;
   localparam int         SETTLE   = 2;
   localparam logic [2:0] RST_R    = 3'd2;

   logic       clk = 1'b0;
   logic       rst;
   logic       clk_en_in;
   logic [1:0] valid;
   logic [2:0] r0, r1;
   logic [1:0] ready;
   logic       div_clk;
   logic [2:0] ratio;
   logic       clk_en_out, busy, done, tmo;
`ifdef CLK_DIV_CTRL_CNT_EN
   logic [7:0] chg_cnt;
`endif

   int ntests = 0;
   int nfail  = 0;

   // reference model state
   logic [2:0] m_ratio;
   int         m_ptr;
   logic       m_tmo;
   logic       cur_en;

   always #5 clk = ~clk;

   clk_div_ctrl dut (
      .i_ref_clk    (clk),
      .i_rst        (rst),
      .i_clk_en     (clk_en_in),
      .i_req_valid  (valid),
      .i_req_ratio0 (r0),
      .i_req_ratio1 (r1),
      .o_req_ready  (ready),
      .i_div_clk    (div_clk),
      .o_div_ratio  (ratio),
      .o_clk_en     (clk_en_out),
      .o_busy       (busy),
      .o_done       (done),
      .o_timeout    (tmo)
`ifdef CLK_DIV_CTRL_CNT_EN
      ,
      .o_chg_cnt    (chg_cnt)
`endif
   );

   task automatic do_reset(input logic en);
      rst = 1'b1; valid = 2'b00; clk_en_in = en;
      repeat (2) @(negedge clk);
      ntests++; if (ratio !== RST_R) begin nfail++; $display("FAIL rst_ratio got %0d exp %0d", ratio, RST_R); end
      ntests++; if (clk_en_out !== 1'b0) begin nfail++; $display("FAIL rst_clk_en got %b exp 0", clk_en_out); end
      ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_busy got %b exp 0", busy); end
      ntests++; if (done !== 1'b0) begin nfail++; $display("FAIL rst_done got %b exp 0", done); end
      ntests++; if (tmo !== 1'b0) begin nfail++; $display("FAIL rst_timeout got %b exp 0", tmo); end
      ntests++; if (ready !== 2'b00) begin nfail++; $display("FAIL rst_ready got %b exp 00", ready); end
      rst = 1'b0;
      @(negedge clk);
      ntests++; if (clk_en_out !== en) begin nfail++; $display("FAIL rel_clk_en got %b exp %b", clk_en_out, en); end
      ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL rel_busy got %b exp 0", busy); end
      m_ratio = RST_R; m_ptr = 0; m_tmo = 1'b0; cur_en = en;
   endtask

   // One request from drive to completion. Called and returns just after a negedge.
   task automatic serve(input logic [1:0] vmask, input logic [2:0] ra0, input logic [2:0] ra1,
                        input bit force_high, input bit abort, input logic en_final);
      int         g, w, L;
      bit         t;
      logic [1:0] exp_ready;
      logic [2:0] nr, old;
      logic       s [1:WAIT_MAX];
      logic       en_drv;

      valid = vmask; r0 = ra0; r1 = ra1;
      div_clk = 1'($urandom_range(0, 1));
      g = (vmask == 2'b11) ? m_ptr : (vmask[1] ? 1 : 0);
      exp_ready = (g == 1) ? 2'b10 : 2'b01;
      #1;
      ntests++; if (ready !== exp_ready) begin nfail++; $display("FAIL ready got %b exp %b", ready, exp_ready); end
      nr  = (g == 1) ? ra1 : ra0;
      old = m_ratio;

      // divided-clock samples seen in WAIT_LOW and the dwell they imply
      for (int k = 1; k <= WAIT_MAX; k++)
         s[k] = force_high ? 1'b1 : ($urandom_range(0, 2) == 0 ? 1'b0 : 1'b1);
      w = WAIT_MAX; t = 1'b1;
      for (int k = 2; k <= WAIT_MAX; k++)
         if (!s[k-1] && !s[k]) begin w = k; t = 1'b0; break; end
      L = 3 + SETTLE + w;

      @(negedge clk);
      valid[g] = 1'b0;
      m_ptr = 1 - g;
      if (nr == old) begin
         ntests++; if (done !== 1'b1) begin nfail++; $display("FAIL same_done got %b exp 1", done); end
         ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL same_busy got %b exp 0", busy); end
         ntests++; if (clk_en_out !== cur_en) begin nfail++; $display("FAIL same_clk_en got %b exp %b", clk_en_out, cur_en); end
         ntests++; if (ratio !== old) begin nfail++; $display("FAIL same_ratio got %0d exp %0d", ratio, old); end
         return;
      end
      ntests++; if (busy !== 1'b0 || done !== 1'b0) begin nfail++; $display("FAIL gate_cycle got busy=%b done=%b exp 0/0", busy, done); end
      ntests++; if (clk_en_out !== cur_en) begin nfail++; $display("FAIL gate_clk_en got %b exp %b", clk_en_out, cur_en); end

      for (int n = 1; n <= L; n++) begin
         div_clk = (n >= 2 && n - 1 <= WAIT_MAX) ? s[n-1] : 1'($urandom_range(0, 1));
         en_drv = (n == L) ? en_final : 1'($urandom_range(0, 1));
         clk_en_in = en_drv;
         if (abort && n == 3 + w) rst = 1'b1;
         @(negedge clk);
         if (abort && n == 3 + w) begin
            ntests++; if (ratio !== RST_R) begin nfail++; $display("FAIL abort_ratio got %0d exp %0d", ratio, RST_R); end
            ntests++; if (busy !== 1'b0 || done !== 1'b0) begin nfail++; $display("FAIL abort_busy_done got %b%b exp 00", busy, done); end
            ntests++; if (clk_en_out !== 1'b0) begin nfail++; $display("FAIL abort_clk_en got %b exp 0", clk_en_out); end
            ntests++; if (tmo !== 1'b0) begin nfail++; $display("FAIL abort_timeout got %b exp 0", tmo); end
            rst = 1'b0; valid = 2'b00;
            @(negedge clk);
            ntests++; if (clk_en_out !== en_drv) begin nfail++; $display("FAIL abort_idle_en got %b exp %b", clk_en_out, en_drv); end
            m_ratio = RST_R; m_ptr = 0; m_tmo = 1'b0; cur_en = en_drv;
            return;
         end
         ntests++; if (busy !== (n < L)) begin nfail++; $display("FAIL busy n=%0d got %b exp %b", n, busy, (n < L)); end
         ntests++; if (done !== (n == L)) begin nfail++; $display("FAIL done n=%0d got %b exp %b", n, done, (n == L)); end
         ntests++; if (clk_en_out !== ((n == L) ? en_final : 1'b0)) begin nfail++; $display("FAIL clk_en n=%0d got %b exp %b", n, clk_en_out, (n == L) ? en_final : 1'b0); end
         ntests++; if (ratio !== ((n >= 2 + w) ? nr : old)) begin nfail++; $display("FAIL ratio n=%0d got %0d exp %0d", n, ratio, (n >= 2 + w) ? nr : old); end
         ntests++; if (tmo !== (m_tmo | (t && n >= 1 + w))) begin nfail++; $display("FAIL timeout n=%0d got %b exp %b", n, tmo, m_tmo | (t && n >= 1 + w)); end
         if (n < L) begin
            ntests++; if (ready !== 2'b00) begin nfail++; $display("FAIL busy_ready n=%0d got %b exp 00", n, ready); end
         end
      end
      m_ratio = nr; m_tmo = m_tmo | t; cur_en = en_final;
   endtask

   task automatic test_reset();
      do_reset(1'b1);
   endtask

   task automatic test_single();
      serve(2'b01, 3'd4, 3'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_both();
      do_reset(1'b1);
      serve(2'b11, 3'd3, 3'd5, 1'b0, 1'b0, 1'b1);
      serve(valid, 3'd3, 3'd5, 1'b0, 1'b0, 1'b1);
      ntests++; if (ratio !== 3'd5) begin nfail++; $display("FAIL both_final got %0d exp 5", ratio); end
   endtask

   task automatic test_same();
      do_reset(1'b1);
      serve(2'b01, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      ntests++; if (done !== 1'b0) begin nfail++; $display("FAIL same_pulse got %b exp 0", done); end
      ntests++; if (busy !== 1'b0 || clk_en_out !== 1'b1) begin nfail++; $display("FAIL same_after got busy=%b en=%b exp 0/1", busy, clk_en_out); end
   endtask

   task automatic test_timeout();
      serve(2'b10, 3'd0, 3'd6, 1'b1, 1'b0, 1'b1);
      serve(2'b01, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1);
      ntests++; if (tmo !== 1'b1) begin nfail++; $display("FAIL timeout_sticky got %b exp 1", tmo); end
   endtask

   task automatic test_abort_and_edges();
      do_reset(1'b1);
      serve(2'b01, 3'd5, 3'd0, 1'b0, 1'b1, 1'b1);
      serve(2'b01, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      ntests++; if (clk_en_out !== 1'b0) begin nfail++; $display("FAIL en0_hold got %b exp 0", clk_en_out); end
      serve(2'b10, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic [1:0] add;
      do_reset(1'b1);
      for (int i = 0; i < 25; i++) begin
         add = 2'($urandom_range(1, 3)) & ~valid;
         if (add[0]) r0 = 3'($urandom_range(0, 7));
         if (add[1]) r1 = 3'($urandom_range(0, 7));
         serve(valid | add, r0, r1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end
      if (valid != 2'b00) serve(valid, r0, r1, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b1; clk_en_in = 1'b1; valid = 2'b00; r0 = 3'd0; r1 = 3'd0; div_clk = 1'b0;
      m_ratio = RST_R; m_ptr = 0; m_tmo = 1'b0; cur_en = 1'b1;
      @(negedge clk);
      test_reset();
      test_single();
      test_both();
      test_same();
      test_timeout();
      test_abort_and_edges();
      test_random();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
